mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter onto a single word-addressed memory port
// Partial-byte writes from requester 1 become a read-modify-write over two cycles.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic        m1_wr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {ISSUE, RMW} state_e;

  state_e      state_q, state_d;
  logic        last_m1_q, last_m1_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic [29:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_wdata_q, rmw_wdata_d;
  logic [3:0]  rmw_be_q, rmw_be_d;
  logic [31:0] merged;

  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (rmw_be_q[i]) merged[8*i +: 8] = rmw_wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wr      = 1'b0;
    state_d     = state_q;
    last_m1_d   = last_m1_q;
    rv0_d       = 1'b0;
    rv1_d       = 1'b0;
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_be_d    = rmw_be_q;
    if (!rst) begin
      if (state_q == RMW) begin
        mem_addr  = rmw_addr_q;
        mem_wdata = merged;
        mem_wr    = 1'b1;
        state_d   = ISSUE;
      end else begin
        // m0 wins contention only when m1 was granted last
        if (m0_req && (!m1_req || last_m1_q)) m0_gnt = 1'b1;
        else if (m1_req)                      m1_gnt = 1'b1;

        if (m0_gnt) begin
          last_m1_d = 1'b0;
          mem_addr  = m0_addr;
          rv0_d     = 1'b1;
        end else if (m1_gnt) begin
          last_m1_d = 1'b1;
          if (!m1_wr) begin
            mem_addr = m1_addr;
            rv1_d    = 1'b1;
          end else if (m1_be == 4'b1111) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wr    = 1'b1;
          end else if (m1_be != 4'b0000) begin
            mem_addr    = m1_addr;
            rmw_addr_d  = m1_addr;
            rmw_wdata_d = m1_wdata;
            rmw_be_d    = m1_be;
            state_d     = RMW;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ISSUE;
      last_m1_q   <= 1'b1;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_m1_q   <= last_m1_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end

  // A read granted just before reset must not report valid while reset is held
  assign m0_rvalid = rv0_q & ~rst;
  assign m1_rvalid = rv1_q & ~rst;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Inputs change just after each falling edge; outputs are checked 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m1_wr;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wr;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem [0:255];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  // Synchronous memory: registered read, write at the issuing edge
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic cyc();
    @(negedge clk);
    m0_req = 0; m1_req = 0; m1_wr = 0; m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  task automatic test_reset();
    cyc(); rst = 1; m0_req = 1; m1_req = 1; m1_wr = 1; m1_be = 4'hF; m1_addr = 30'h9; m1_wdata = 32'h1;
    #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL reset_gnt got %b want 00", {m0_gnt, m1_gnt}); else passed++;
    total++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %b want 0", mem_wr); else passed++;
    cyc(); rst = 1; #1;
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL reset_rvalid got %b want 00", {m0_rvalid, m1_rvalid}); else passed++;
    cyc(); rst = 0; #1;
    total++; if (mem_addr !== 30'h0 || mem_wdata !== 32'h0 || mem_wr !== 1'b0)
      $display("FAIL idle_mem got %h/%h/%b want 0/0/0", mem_addr, mem_wdata, mem_wr); else passed++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [0:3] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [29:0] exp_a [0:3] = '{30'h10, 30'h20, 30'h10, 30'h20};
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 4) begin m0_req = 1; m0_addr = 30'h10; m1_req = 1; m1_addr = 30'h20; end
      #1;
      if (i < 4) begin
        total++; if ({m0_gnt, m1_gnt} !== exp_g[i] || mem_addr !== exp_a[i])
          $display("FAIL cont_gnt%0d got %b@%h want %b@%h", i, {m0_gnt, m1_gnt}, mem_addr, exp_g[i], exp_a[i]); else passed++;
      end
      if (i > 0) begin
        total++; if ({m0_rvalid, m1_rvalid} !== exp_g[i-1] || m0_rdata !== (32'hA000_0000 | 32'(exp_a[i-1])))
          $display("FAIL cont_rv%0d got %b/%h want %b/%h", i, {m0_rvalid, m1_rvalid}, m0_rdata, exp_g[i-1], 32'hA000_0000 | 32'(exp_a[i-1])); else passed++;
      end
    end
  endtask

  task automatic test_full_write();
    cyc(); m1_req = 1; m1_wr = 1; m1_be = 4'hF; m1_addr = 30'h5; m1_wdata = 32'hDEADBEEF; #1;
    total++; if (m1_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 30'h5 || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL fw_issue got g%b w%b %h %h want 1 1 5 deadbeef", m1_gnt, mem_wr, mem_addr, mem_wdata); else passed++;
    cyc(); m1_req = 1; m1_addr = 30'h5; #1;
    total++; if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b0 || mem_wr !== 1'b0)
      $display("FAIL fw_read got g%b rv%b w%b want 1 0 0", m1_gnt, m1_rvalid, mem_wr); else passed++;
    cyc(); #1;
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF)
      $display("FAIL fw_rdata got %b/%h want 1/deadbeef", m1_rvalid, m1_rdata); else passed++;
  endtask

  task automatic test_rmw();
    cyc(); m1_req = 1; m1_wr = 1; m1_be = 4'b0011; m1_addr = 30'h5; m1_wdata = 32'h00001122; #1;
    total++; if (m1_gnt !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 30'h5)
      $display("FAIL rmw_n got g%b w%b %h want 1 0 5", m1_gnt, mem_wr, mem_addr); else passed++;
    cyc(); m0_req = 1; m0_addr = 30'h5; #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00 || mem_wr !== 1'b1 || mem_addr !== 30'h5 || mem_wdata !== 32'hDEAD1122)
      $display("FAIL rmw_n1 got g%b w%b %h %h want 00 1 5 dead1122", {m0_gnt, m1_gnt}, mem_wr, mem_addr, mem_wdata); else passed++;
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rmw_n1_rv got %b want 00", {m0_rvalid, m1_rvalid}); else passed++;
    cyc(); m0_req = 1; m0_addr = 30'h5; #1;
    total++; if (m0_gnt !== 1'b1 || mem_addr !== 30'h5) $display("FAIL rmw_n2 got g%b %h want 1 5", m0_gnt, mem_addr); else passed++;
    cyc(); #1;
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD1122)
      $display("FAIL rmw_n3 got %b/%h want 1/dead1122", m0_rvalid, m0_rdata); else passed++;
  endtask

  task automatic test_noop();
    cyc(); m1_req = 1; m1_wr = 1; m1_be = 4'b0000; m1_addr = 30'h5; m1_wdata = 32'hFFFFFFFF; #1;
    total++; if (m1_gnt !== 1'b1 || mem_wr !== 1'b0) $display("FAIL noop_issue got g%b w%b want 1 0", m1_gnt, mem_wr); else passed++;
    cyc(); m1_req = 1; m1_addr = 30'h5; #1;
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00 || m1_gnt !== 1'b1)
      $display("FAIL noop_next got rv%b g%b want 00 1", {m0_rvalid, m1_rvalid}, m1_gnt); else passed++;
    cyc(); #1;
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEAD1122)
      $display("FAIL noop_mem got %b/%h want 1/dead1122", m1_rvalid, m1_rdata); else passed++;
  endtask

  task automatic test_reset_rmw();
    cyc(); m1_req = 1; m1_wr = 1; m1_be = 4'b0001; m1_addr = 30'h6; m1_wdata = 32'h000000FF; #1;
    total++; if (m1_gnt !== 1'b1) $display("FAIL rrmw_n got g%b want 1", m1_gnt); else passed++;
    cyc(); rst = 1; #1;
    total++; if (mem_wr !== 1'b0 || {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000)
      $display("FAIL rrmw_abort got w%b g/rv %b want 0 0000", mem_wr, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); else passed++;
    cyc(); rst = 0; m0_req = 1; m0_addr = 30'h6; m1_req = 1; m1_addr = 30'h7; #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10 || mem_wr !== 1'b0)
      $display("FAIL rrmw_first got %b w%b want 10 0", {m0_gnt, m1_gnt}, mem_wr); else passed++;
    cyc(); m1_req = 1; m1_addr = 30'h7; #1;
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA0000006)
      $display("FAIL rrmw_mem got %b/%h want 1/a0000006", m0_rvalid, m0_rdata); else passed++;
    cyc(); #1;
  endtask

  task automatic test_read_before_reset();
    cyc(); m0_req = 1; m0_addr = 30'h2AAAAAA5; #1;
    total++; if (m0_gnt !== 1'b1 || mem_addr !== 30'h2AAAAAA5)
      $display("FAIL wide_addr got g%b %h want 1 2aaaaaa5", m0_gnt, mem_addr); else passed++;
    cyc(); rst = 1; #1;
    total++; if (m0_rvalid !== 1'b0) $display("FAIL rbr_rv got %b want 0", m0_rvalid); else passed++;
    cyc(); rst = 0; #1;
    total++; if (m0_rvalid !== 1'b0) $display("FAIL rbr_rv_after got %b want 0", m0_rvalid); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (i < 8) begin m0_req = 1; m0_addr = 30'h40 + 30'(i); end
      #1;
      if (i < 8) begin
        total++; if (m0_gnt !== 1'b1 || mem_addr !== 30'h40 + 30'(i))
          $display("FAIL b2b_gnt%0d got g%b %h want 1 %h", i, m0_gnt, mem_addr, 30'h40 + 30'(i)); else passed++;
      end
      if (i > 0) begin
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA0000040 + 32'(i - 1))
          $display("FAIL b2b_rv%0d got %b/%h want 1/%h", i, m0_rvalid, m0_rdata, 32'hA0000040 + 32'(i - 1)); else passed++;
      end
    end
    cyc(); #1;
    total++; if (m0_rvalid !== 1'b0) $display("FAIL b2b_end got %b want 0", m0_rvalid); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    rst = 1; m0_req = 0; m1_req = 0; m1_wr = 0; m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_contention();
    test_full_write();
    test_rmw();
    test_noop();
    test_reset_rmw();
    test_read_before_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
